// File: rtl/tl_vc_arbiter.sv
// Transaction-layer VC arbiter: sequences RESET/INIT/IDLE/ACTIVE, distributes the
// Umbral thresholds, grants one input FIFO per cycle by fixed priority and counts words per output.
module tl_vc_arbiter #(
    parameter int DATA_W   = 12,
    parameter int DEST_LSB = 8,
    parameter int CNT_W    = 5,
    parameter int UMB_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [UMB_W-1:0]      umbral_bajo_in,
    input  logic [UMB_W-1:0]      umbral_alto_in,
    output logic [UMB_W-1:0]      umbral_bajo,
    output logic [UMB_W-1:0]      umbral_alto,
    input  logic [3:0]            in_empty,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic [3:0]            in_pop,
    input  logic [3:0]            out_almost_full,
    input  logic [3:0]            out_full,
    output logic [3:0]            out_push,
    output logic [DATA_W-1:0]     out_data,
    input  logic                  req,
    input  logic [1:0]            idx,
    output logic [CNT_W-1:0]      contador,
    output logic                  valid,
    output logic                  idle,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    function automatic logic [1:0] dest_of(input logic [DATA_W-1:0] word);
        return word[DEST_LSB +: 2];
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] sel);
        return 4'd1 << sel;
    endfunction

    state_t              state_q, state_d;
    logic [UMB_W-1:0]    umb_bajo_q, umb_alto_q;
    logic [3:0]          push_q, push_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q [4];
    logic [CNT_W-1:0]    cont_q;
    logic                valid_q;
    logic [3:0]          cand_s, grant_s;
    logic [DATA_W-1:0]   sel_word_s;
    logic                arb_en_s, pending_s;

    assign arb_en_s  = (state_q == ST_ACTIVE) && !init;
    assign pending_s = |push_q;

    // Candidate inputs: non-empty and destination output has room
    always_comb begin
        cand_s = 4'd0;
        for (int i = 0; i < 4; i++) begin
            cand_s[i] = ~in_empty[i]
                      & ~out_almost_full[dest_of(in_data[i*DATA_W +: DATA_W])]
                      & ~out_full[dest_of(in_data[i*DATA_W +: DATA_W])];
        end
    end

    // Isolating the lowest set bit gives input 0 the highest priority
    assign grant_s = arb_en_s ? (cand_s & (~cand_s + 4'd1)) : 4'd0;

    // Route the granted head word towards its destination output
    always_comb begin
        sel_word_s = {DATA_W{1'b0}};
        case (grant_s)
            4'b0001: sel_word_s = in_data[0*DATA_W +: DATA_W];
            4'b0010: sel_word_s = in_data[1*DATA_W +: DATA_W];
            4'b0100: sel_word_s = in_data[2*DATA_W +: DATA_W];
            4'b1000: sel_word_s = in_data[3*DATA_W +: DATA_W];
            default: sel_word_s = {DATA_W{1'b0}};
        endcase
        push_d = (|grant_s) ? onehot4(dest_of(sel_word_s)) : 4'd0;
        data_d = (|grant_s) ? sel_word_s : data_q;
    end

    // Phase sequencing; leaving ACTIVE waits for the in-flight push
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT:  state_d = init ? ST_INIT : ST_IDLE;
            ST_IDLE: begin
                if (init)              state_d = ST_INIT;
                else if (!(&in_empty)) state_d = ST_ACTIVE;
                else                   state_d = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (pending_s)         state_d = ST_ACTIVE;
                else if (init)         state_d = ST_INIT;
                else if (&in_empty)    state_d = ST_IDLE;
                else                   state_d = ST_ACTIVE;
            end
            default: state_d = ST_RESET;
        endcase
    end

    // State, thresholds and push pipeline registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            umb_bajo_q <= {UMB_W{1'b0}};
            umb_alto_q <= {UMB_W{1'b0}};
            push_q     <= 4'd0;
            data_q     <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            push_q  <= push_d;
            data_q  <= data_d;
            if (state_q == ST_INIT) begin
                umb_bajo_q <= umbral_bajo_in;
                umb_alto_q <= umbral_alto_in;
            end else begin
                umb_bajo_q <= umb_bajo_q;
                umb_alto_q <= umb_alto_q;
            end
        end
    end

    // Per-output counters and readback; a read returns the pre-increment value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 4; d++) begin
                cnt_q[d] <= {CNT_W{1'b0}};
            end
            cont_q  <= {CNT_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (push_q[d]) cnt_q[d] <= cnt_q[d] + CNT_W'(1);
                else           cnt_q[d] <= cnt_q[d];
            end
            if (req && (state_q != ST_RESET)) begin
                cont_q  <= cnt_q[idx];
                valid_q <= 1'b1;
            end else begin
                cont_q  <= cont_q;
                valid_q <= 1'b0;
            end
        end
    end

    assign in_pop      = grant_s;
    assign out_push    = push_q;
    assign out_data    = data_q;
    assign umbral_bajo = umb_bajo_q;
    assign umbral_alto = umb_alto_q;
    assign contador    = cont_q;
    assign valid       = valid_q;
    assign idle        = (state_q == ST_IDLE);
    assign state       = state_q;

endmodule
